// File: rtl/audio_decimator.sv
// audio_decimator
//   Block-averaging decimator for the output of an IIR audio stage. Samples
//   "in" once every "div" clock cycles, sums 2^shift samples into a widened
//   accumulator, and pushes the arithmetically-shifted average into a small
//   output FIFO with a valid/ready handshake and a sticky overrun flag.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   div        sample interval in clk cycles (0 and 1 both mean every cycle)
//   shift      log2 of the decimation ratio (5..7 behave as 4)
//   in         signed input sample
//   out        signed FIFO head sample, 0 while the FIFO is empty
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts the head sample
//   ovr        sticky overrun flag (result dropped on a full FIFO)
//   ovr_clr    clears ovr
module audio_decimator #(
    parameter int DATA_WIDTH = 16,
    parameter int COUNT_BITS = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [COUNT_BITS-1:0]        div,
    input  logic [2:0]                   shift,
    input  logic signed [DATA_WIDTH-1:0] in,
    output logic signed [DATA_WIDTH-1:0] out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         ovr,
    input  logic                         ovr_clr
);

    localparam int ACC_W = DATA_WIDTH + 4;
    localparam int AW    = $clog2(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Sample-interval counter
    // ------------------------------------------------------------------
    logic [COUNT_BITS-1:0] count_reg;
    logic                  tick;

    // ">=" rather than "==" so that lowering div below the current count
    // wraps immediately instead of running through the full counter range.
    always_comb begin
        tick = (div <= COUNT_BITS'(1)) || (count_reg >= (div - COUNT_BITS'(1)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + COUNT_BITS'(1);
        end
    end

    // ------------------------------------------------------------------
    // Block accumulator
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] acc_reg;
    logic [3:0]              smp_cnt_reg;
    logic [2:0]              shift_lat_reg;

    logic [2:0]              shift_clamped;
    logic [2:0]              shift_eff;
    logic [4:0]              smp_last;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    logic signed [DATA_WIDTH-1:0] result;
    logic                    block_done;

    always_comb begin
        shift_clamped = (shift > 3'd4) ? 3'd4 : shift;
        // The first tick of a block uses (and latches) the live shift; the
        // rest of the block keeps the latched value.
        shift_eff  = (smp_cnt_reg == 4'd0) ? shift_clamped : shift_lat_reg;
        smp_last   = (5'd1 << shift_eff) - 5'd1;
        sum        = acc_reg + $signed({{4{in[DATA_WIDTH-1]}}, in});
        shifted    = sum >>> shift_eff;
        // The average of DATA_WIDTH-bit samples always fits DATA_WIDTH bits.
        result     = shifted[DATA_WIDTH-1:0];
        block_done = tick && ({1'b0, smp_cnt_reg} == smp_last);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg       <= '0;
            smp_cnt_reg   <= '0;
            shift_lat_reg <= '0;
        end else if (tick) begin
            shift_lat_reg <= shift_eff;
            if (block_done) begin
                acc_reg     <= '0;
                smp_cnt_reg <= '0;
            end else begin
                acc_reg     <= sum;
                smp_cnt_reg <= smp_cnt_reg + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   occ_reg;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          overrun;

    always_comb begin
        out_valid = (occ_reg != '0);
        full      = (occ_reg == (AW+1)'(FIFO_DEPTH));
        pop       = out_valid && out_ready;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        push_ok   = block_done && (!full || pop);
        overrun   = block_done && full && !pop;
        out       = out_valid ? mem[rd_ptr_reg] : '0;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= result;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   occ_reg <= occ_reg + (AW+1)'(1);
                2'b01:   occ_reg <= occ_reg - (AW+1)'(1);
                default: occ_reg <= occ_reg;
            endcase
        end
    end

    // A fresh overrun wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr <= 1'b0;
        end else if (overrun) begin
            ovr <= 1'b1;
        end else if (ovr_clr) begin
            ovr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_decimator.sv
// tb_audio_decimator
//   Directed testbench for audio_decimator: interval timing, block averaging,
//   shift latching/clamping, FIFO fill/overrun/drain, simultaneous push+pop,
//   sticky overrun clear and asynchronous mid-block reset.
module tb_audio_decimator;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [9:0]         div = 10'd4;
    logic [2:0]         shift = 3'd0;
    logic signed [15:0] in = '0;
    logic signed [15:0] out;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               ovr;
    logic               ovr_clr = 1'b0;

    int checks = 0;
    int failures = 0;
    int n;

    audio_decimator #(
        .DATA_WIDTH(16),
        .COUNT_BITS(10),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .div      (div),
        .shift    (shift),
        .in       (in),
        .out      (out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ovr      (ovr),
        .ovr_clr  (ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Steps until out_valid, bounded; returns the number of edges waited.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 64) begin
            step();
            cyc++;
        end
        if (!out_valid) check("wait_valid_timeout", 0, 1);
    endtask

    initial begin
        // ---- reset state ----
        step();
        check("rst_valid", int'(out_valid), 0);
        check("rst_out", int'(out), 0);
        check("rst_ovr", int'(ovr), 0);

        // ---- div=4, shift=0, in=100, out_ready=1 ----
        div = 10'd4; shift = 3'd0; in = 16'sd100; out_ready = 1'b1;
        do_reset();
        wait_valid(n);
        check("p1_first_latency", n, 4);
        check("p1_out", int'(out), 100);
        step();
        check("p1_pulse_end", int'(out_valid), 0);
        check("p1_out_idle", int'(out), 0);
        wait_valid(n);
        check("p1_period_gap", n, 3);
        check("p1_out2", int'(out), 100);

        // ---- div=2, shift=2: 10,20,30,41 -> 25 ; -1,-1,-1,-2 -> -2 ----
        div = 10'd2; shift = 3'd2; out_ready = 1'b0;
        do_reset();
        in = 16'sd10; step(); step();
        in = 16'sd20; step(); step();
        in = 16'sd30; step(); step();
        check("avg_partial_valid", int'(out_valid), 0);
        in = 16'sd41; step(); step();
        check("avg_valid", int'(out_valid), 1);
        check("avg_out", int'(out), 25);
        out_ready = 1'b1; step();
        out_ready = 1'b0;
        in = -16'sd1; step();
        shift = 3'd0;            // mid-block change must not apply yet
        step(); step();
        step(); step();
        in = -16'sd2; step(); step();
        check("neg_valid", int'(out_valid), 1);
        check("neg_out", int'(out), -2);
        out_ready = 1'b1; step();
        out_ready = 1'b0;

        // ---- shift=7 clamps to 4, div=1, in=-32768 ----
        div = 10'd1; shift = 3'd7; in = -16'sd32768; out_ready = 1'b0;
        do_reset();
        wait_valid(n);
        check("clamp_latency", n, 16);
        check("clamp_out", int'(out), -32768);
        out_ready = 1'b1; step();
        out_ready = 1'b0;
        wait_valid(n);
        check("clamp_gap", n, 15);
        check("clamp_out2", int'(out), -32768);

        // ---- fill with out_ready=0, overrun, drain ----
        div = 10'd1; shift = 3'd0; out_ready = 1'b0; in = 16'sd1;
        do_reset();
        step();
        check("fill_valid", int'(out_valid), 1);
        check("fill_out", int'(out), 1);
        in = 16'sd2; step();
        in = 16'sd3; step();
        in = 16'sd4; step();
        check("fill_ovr_full", int'(ovr), 0);
        in = 16'sd5; step();
        check("fill_ovr_set", int'(ovr), 1);
        check("fill_head_stable", int'(out), 1);
        div = 10'd1023; out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain_%0d", k), int'(out), k);
            step();
        end
        check("drain_empty", int'(out_valid), 0);
        check("drain_empty_out", int'(out), 0);
        check("ovr_sticky", int'(ovr), 1);
        out_ready = 1'b0; ovr_clr = 1'b1; step();
        ovr_clr = 1'b0;
        check("ovr_cleared", int'(ovr), 0);

        // ---- full + simultaneous push/pop, then overrun with clear ----
        div = 10'd1; shift = 3'd0; out_ready = 1'b0;
        do_reset();
        for (int v = 10; v <= 13; v++) begin
            in = 16'(v);
            step();
        end
        in = 16'sd14; out_ready = 1'b1; step();
        check("pushpop_ovr", int'(ovr), 0);
        out_ready = 1'b0; in = 16'sd99; ovr_clr = 1'b1; step();
        ovr_clr = 1'b0; div = 10'd1023;
        check("ovr_clr_vs_set", int'(ovr), 1);
        check("pushpop_head", int'(out), 11);
        out_ready = 1'b1;
        for (int k = 11; k <= 14; k++) begin
            check($sformatf("pp_drain_%0d", k), int'(out), k);
            step();
        end
        check("pp_empty", int'(out_valid), 0);
        out_ready = 1'b0;

        // ---- asynchronous reset mid-block ----
        div = 10'd1; shift = 3'd0;
        do_reset();
        in = 16'sd7; step();
        in = 16'sd8; step();
        check("pre_rst_head", int'(out), 7);
        shift = 3'd2; in = 16'sd50; step();
        #2 reset = 1'b1;
        #1;
        check("arst_valid", int'(out_valid), 0);
        check("arst_out", int'(out), 0);
        check("arst_ovr", int'(ovr), 0);
        in = 16'sd4; shift = 3'd2;
        step();
        reset = 1'b0;
        wait_valid(n);
        check("post_rst_latency", n, 4);
        check("post_rst_out", int'(out), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
